// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: combinational hit/instr lookup plus a
// two-state miss-refill engine that fills one line word-serially from memory.
module icache_ctrl #(
    parameter int OFFSET_BITS = 2,
    parameter int INDEX_BITS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        rd_en,
    input  logic        flush,
    output logic        hit,
    output logic [31:0] instr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int TAG_W  = 30 - OFFSET_BITS - INDEX_BITS;
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int WORDS  = 1 << OFFSET_BITS;
    localparam int IDX_LO = OFFSET_BITS + 2;
    localparam int TAG_LO = IDX_LO + INDEX_BITS;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state, next_state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES*WORDS];

    logic [OFFSET_BITS-1:0]  offset;
    logic [INDEX_BITS-1:0]   index;
    logic [TAG_W-1:0]        tag;

    logic [OFFSET_BITS-1:0]  count;
    logic [INDEX_BITS-1:0]   ref_index;
    logic [TAG_W-1:0]        ref_tag;
    logic                    flush_pend;

    logic                    lookup_hit;
    logic                    start_refill;
    logic                    accept_word;
    logic                    last_word;
    logic                    unused_pc_bits;

    assign offset         = pc[IDX_LO-1:2];
    assign index          = pc[TAG_LO-1:IDX_LO];
    assign tag            = pc[31:TAG_LO];
    assign unused_pc_bits = ^pc[1:0];

    // Lookup is only trusted in IDLE so a line being refilled never reports a hit.
    assign lookup_hit = (state == IDLE) && valid[index] && (tag_mem[index] == tag);
    assign hit        = !rd_en || lookup_hit;
    assign instr      = (rd_en && lookup_hit) ? data_mem[{index, offset}] : 32'h0000_0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        start_refill = 1'b0;
        accept_word  = 1'b0;
        last_word    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en && !lookup_hit && !flush) begin
                    start_refill = 1'b1;
                    next_state   = REFILL;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    accept_word = 1'b1;
                    if (&count) begin
                        last_word  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            count      <= '0;
            flush_pend <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0000_0000;
        end else begin
            // A flush landing on the final word still leaves the new line invalid.
            if (flush) begin
                valid <= '0;
            end else if (last_word && !flush_pend) begin
                valid[ref_index] <= 1'b1;
            end

            if (start_refill || last_word) begin
                flush_pend <= 1'b0;
            end else if (state == REFILL && flush) begin
                flush_pend <= 1'b1;
            end

            if (start_refill) begin
                count    <= '0;
                mem_req  <= 1'b1;
                mem_addr <= {pc[31:IDX_LO], {IDX_LO{1'b0}}};
            end else if (accept_word) begin
                count    <= count + 1'b1;
                mem_addr <= mem_addr + 32'd4;
                if (last_word) begin
                    mem_req <= 1'b0;
                end
            end
        end
    end

    // Storage arrays and the latched refill target carry no reset.
    always_ff @(posedge clk) begin
        if (start_refill) begin
            ref_index <= index;
            ref_tag   <= tag;
        end
        if (accept_word) begin
            data_mem[{ref_index, count}] <= mem_rdata;
        end
        if (last_word) begin
            tag_mem[ref_index] <= ref_tag;
        end
    end

endmodule
